// File: rtl/dotseq_pkg.sv
// ============================================================================
// Module      : dotseq_pkg
// Description : Shared state encoding, default widths and credit sizing for
//               the dot-product sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dotseq_pkg;

  localparam int c_DATA_WIDTH      = 32;
  localparam int c_ADDR_WIDTH      = 5;
  localparam int c_RESULT_WIDTH    = 16;
  localparam int c_MAX_OUTSTANDING = 8;
  localparam int c_PERF_WIDTH      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dotseq_state_t;

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  function automatic int dotseq_credit_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

  localparam int c_CREDIT_WIDTH = dotseq_credit_width(c_MAX_OUTSTANDING);

endpackage

`default_nettype wire

// File: rtl/dotseq_perf.sv
// ============================================================================
// Module      : dotseq_perf
// Description : Saturating job-cycle and blocked-issue counters, cleared when
//               a job is accepted and held until the next acceptance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dotseq_perf
  import dotseq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_cycle_en,
  input  logic                    i_stall,
  output logic [c_PERF_WIDTH-1:0] o_cycles,
  output logic [c_PERF_WIDTH-1:0] o_stalls
);

  logic [c_PERF_WIDTH-1:0] r_cycles;
  logic [c_PERF_WIDTH-1:0] r_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
      r_stalls <= '0;
    end else begin
      // The accepting cycle itself is the first counted cycle of the job.
      if (i_clear) begin
        r_cycles <= c_PERF_WIDTH'(1);
        r_stalls <= '0;
      end else begin
        if (i_cycle_en && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
        if (i_stall && (r_stalls != '1))    r_stalls <= r_stalls + 1'b1;
      end
    end
  end

  assign o_cycles = r_cycles;
  assign o_stalls = r_stalls;

endmodule

`default_nettype wire

// File: rtl/dot_product_sequencer.sv
// ============================================================================
// Module      : dot_product_sequencer
// Description : Issues operand reads into a credit-limited pipeline and
//               retires results into mem3; optional DOTSEQ_PERF_EN counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dot_product_sequencer
  import dotseq_pkg::*;
#(
  parameter int DATA_WIDTH      = c_DATA_WIDTH,
  parameter int ADDR_WIDTH      = c_ADDR_WIDTH,
  parameter int RESULT_WIDTH    = c_RESULT_WIDTH,
  parameter int MAX_OUTSTANDING = c_MAX_OUTSTANDING
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_base,
  input  logic [ADDR_WIDTH-1:0]   dst_base,
  input  logic [ADDR_WIDTH:0]     vec_count,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    op_push,
  input  logic                    op_full_a,
  input  logic                    op_full_b,
  input  logic                    res_valid,
  input  logic [RESULT_WIDTH-1:0] res_data,
  output logic                    res_pop,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stalls
);

  localparam int                    c_CREDIT_W   = dotseq_credit_width(MAX_OUTSTANDING);
  localparam logic [c_CREDIT_W-1:0] c_CREDIT_MAX = c_CREDIT_W'(MAX_OUTSTANDING);

  dotseq_state_t           r_state;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic [ADDR_WIDTH-1:0]   r_dst;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [ADDR_WIDTH:0]     r_issued;
  logic [ADDR_WIDTH:0]     r_retired;
  logic [c_CREDIT_W-1:0]   r_credit;
  logic                    r_op_push;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;

  logic w_active;
  logic w_issue;
  logic w_pop;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_issue  = (r_state == ST_RUN) && (r_issued < r_cnt) && !op_full_a && !op_full_b
                    && (r_credit < c_CREDIT_MAX);
  assign w_pop    = w_active && res_valid && (r_retired < r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_issued  <= '0;
      r_retired <= '0;
      r_credit  <= '0;
      r_op_push <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_op_push <= w_issue;
      r_wr_en   <= w_pop;

      if (w_issue) r_issued <= r_issued + 1'b1;

      if (w_pop) begin
        r_wr_addr <= r_dst + r_retired[ADDR_WIDTH-1:0];
        r_wr_data <= DATA_WIDTH'(res_data);
        r_retired <= r_retired + 1'b1;
      end

      case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src     <= src_base;
            r_dst     <= dst_base;
            r_cnt     <= vec_count;
            r_issued  <= '0;
            r_retired <= '0;
            r_credit  <= '0;
            r_state   <= (vec_count == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_issued == r_cnt) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // retired reaches the count in the same cycle the last write is presented.
          if (r_retired == r_cnt) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_en   = w_issue;
  assign rd_addr = r_src + r_issued[ADDR_WIDTH-1:0];
  assign op_push = r_op_push;
  assign res_pop = w_pop;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = w_active;
  assign done    = (r_state == ST_DONE);

`ifdef DOTSEQ_PERF_EN
  logic w_accept;
  logic w_stall;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_stall  = (r_state == ST_RUN) && (r_issued < r_cnt) && !w_issue;

  dotseq_perf u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept),
    .i_cycle_en (r_state != ST_IDLE),
    .i_stall    (w_stall),
    .o_cycles   (perf_cycles),
    .o_stalls   (perf_stalls)
  );
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
// ============================================================================
// Module      : tb_dot_product_sequencer
// Description : Directed self-checking bench for dot_product_sequencer with a
//               behavioural result FIFO returning data three cycles after push.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dot_product_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RW = 16;
  localparam int MO = 8;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW:0]   vec_count = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          op_push;
  logic          op_full_a = 1'b0;
  logic          op_full_b = 1'b0;
  logic          res_valid = 1'b0;
  logic [RW-1:0] res_data = '0;
  logic          res_pop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stalls;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .vec_count(vec_count), .rd_en(rd_en), .rd_addr(rd_addr), .op_push(op_push),
    .op_full_a(op_full_a), .op_full_b(op_full_b), .res_valid(res_valid), .res_data(res_data),
    .res_pop(res_pop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  // Per-job observation logs, filled by run_job.
  int            rd_addr_q[$];
  int            rd_cyc_q[$];
  int            wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            rq_ready[$];
  logic [RW-1:0] rq_data[$];
  int done_cnt, done_cyc, push_err, max_out, busy_after, push_idx;

  // Drives one job cycle-by-cycle; entered and left at posedge+1.
  task automatic run_job(input int src, input int dst, input int cnt, input int full_lo,
                         input int full_hi, input int hold_until, input int glitch,
                         input int rst_at, input int budget);
    int  outst;
    bit  prev_rd;
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    rq_ready.delete(); rq_data.delete();
    done_cnt = 0; done_cyc = -1; push_err = 0; max_out = 0; busy_after = 0; push_idx = 0;
    outst = 0; prev_rd = 1'b0;
    for (int c = 0; c < budget; c++) begin
      start     = (c == 0) || (c == glitch);
      src_base  = (c == glitch) ? AW'(20) : AW'(src);
      dst_base  = AW'(dst);
      vec_count = (c == glitch) ? (AW+1)'(31) : (AW+1)'(cnt);
      op_full_a = (c >= full_lo) && (c <= full_hi);
      res_valid = (c >= hold_until) && (rq_ready.size() > 0) && (rq_ready.size() > 0 ? rq_ready[0] <= c : 1'b0);
      res_data  = (rq_data.size() > 0) ? rq_data[0] : '0;
      if (c == rst_at) return;
      @(negedge clk);
      if (op_push !== prev_rd) push_err++;
      prev_rd = rd_en;
      if (rd_en) begin
        rd_addr_q.push_back(int'(rd_addr));
        rd_cyc_q.push_back(c);
        outst++;
      end
      if (res_pop && rq_ready.size() > 0) begin
        void'(rq_ready.pop_front());
        void'(rq_data.pop_front());
        outst--;
      end
      if (op_push) begin
        rq_ready.push_back(c + 3);
        rq_data.push_back(RW'(32'h1000 + push_idx * 32'h111));
        push_idx++;
      end
      if (wr_en) begin
        wr_addr_q.push_back(int'(wr_addr));
        wr_data_q.push_back(wr_data);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc && busy) busy_after++;
      if (outst > max_out) max_out = outst;
      @(posedge clk); #1;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    op_full_a = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, op_push, res_pop, wr_en, busy, done} !== 6'b0 || rd_addr !== '0 ||
        wr_addr !== '0 || wr_data !== '0 || perf_cycles !== '0 || perf_stalls !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b push=%b pop=%b wr=%b busy=%b done=%b, want all 0",
               rd_en, op_push, res_pop, wr_en, busy, done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job(0, 8, 4, NEVER, -1, 0, 3, -1, 100);
    checks++;
    if (done_cnt !== 1 || done_cyc !== 10) begin
      errors++; $display("FAIL basic_done: got count=%0d cycle=%0d, want 1 at 10", done_cnt, done_cyc);
    end
    checks++;
    if (rd_addr_q.size() !== 4) begin
      errors++; $display("FAIL basic_rd_count: got %0d, want 4", rd_addr_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ((k < rd_addr_q.size() ? rd_addr_q[k] : -1) !== k ||
          (k < rd_cyc_q.size() ? rd_cyc_q[k] : -1) !== k + 1) begin
        errors++; $display("FAIL basic_rd_%0d: wrong address or cycle, want addr %0d at cycle %0d", k, k, k + 1);
      end
      checks++;
      if ((k < wr_addr_q.size() ? wr_addr_q[k] : -1) !== 8 + k ||
          (k < wr_data_q.size() ? wr_data_q[k] : 'x) !== DW'(32'h1000 + k * 32'h111)) begin
        errors++; $display("FAIL basic_wr_%0d: wrong write, want addr %0d data %h", k, 8 + k, 32'h1000 + k * 32'h111);
      end
    end
    checks++;
    if (wr_addr_q.size() !== 4 || push_err !== 0 || busy_after !== 0) begin
      errors++; $display("FAIL basic_misc: got writes=%0d push_err=%0d busy_after=%0d, want 4/0/0",
                         wr_addr_q.size(), push_err, busy_after);
    end
    checks++;
`ifdef DOTSEQ_PERF_EN
    if (perf_cycles !== 32'd11 || perf_stalls !== 32'd0) begin
      errors++; $display("FAIL basic_perf: got cycles=%0d stalls=%0d, want 11/0", perf_cycles, perf_stalls);
    end
`else
    if (perf_cycles !== 32'd0 || perf_stalls !== 32'd0) begin
      errors++; $display("FAIL basic_perf_off: got cycles=%0d stalls=%0d, want 0/0", perf_cycles, perf_stalls);
    end
`endif
  endtask

  task automatic test_backpressure();
    int want_cyc[4] = '{1, 6, 7, 8};
    run_job(0, 8, 4, 2, 5, 0, -1, -1, 100);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ((k < rd_addr_q.size() ? rd_addr_q[k] : -1) !== k ||
          (k < rd_cyc_q.size() ? rd_cyc_q[k] : -1) !== want_cyc[k]) begin
        errors++; $display("FAIL bp_rd_%0d: wrong address or cycle, want addr %0d at cycle %0d", k, k, want_cyc[k]);
      end
    end
    checks++;
    if (done_cyc !== 14 || wr_addr_q.size() !== 4 || push_err !== 0) begin
      errors++; $display("FAIL bp_done: got done at %0d writes=%0d push_err=%0d, want 14/4/0",
                         done_cyc, wr_addr_q.size(), push_err);
    end
`ifdef DOTSEQ_PERF_EN
    checks++;
    if (perf_stalls !== 32'd4 || perf_cycles !== 32'd15) begin
      errors++; $display("FAIL bp_perf: got stalls=%0d cycles=%0d, want 4/15", perf_stalls, perf_cycles);
    end
`endif
  endtask

  task automatic test_credit();
    int early;
    run_job(0, 0, 12, NEVER, -1, 20, -1, -1, 200);
    early = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] < 20) early++;
    checks++;
    if (early !== 8 || max_out !== MO) begin
      errors++; $display("FAIL credit_limit: got %0d reads before release, max in flight %0d, want 8/8", early, max_out);
    end
    checks++;
    if (rd_cyc_q.size() !== 12 || (rd_cyc_q.size() > 8 ? rd_cyc_q[8] : -1) !== 21) begin
      errors++; $display("FAIL credit_resume: got %0d reads, want 12 with the 9th at cycle 21", rd_cyc_q.size());
    end
    checks++;
    if (wr_addr_q.size() !== 12 || done_cyc !== 33) begin
      errors++; $display("FAIL credit_done: got writes=%0d done at %0d, want 12 at 33", wr_addr_q.size(), done_cyc);
    end
    for (int k = 0; k < 12; k += 11) begin
      checks++;
      if ((k < wr_addr_q.size() ? wr_addr_q[k] : -1) !== k ||
          (k < wr_data_q.size() ? wr_data_q[k] : 'x) !== DW'(32'h1000 + k * 32'h111)) begin
        errors++; $display("FAIL credit_wr_%0d: wrong write, want addr %0d data %h", k, k, 32'h1000 + k * 32'h111);
      end
    end
`ifdef DOTSEQ_PERF_EN
    checks++;
    if (perf_stalls !== 32'd12 || perf_cycles !== 32'd34) begin
      errors++; $display("FAIL credit_perf: got stalls=%0d cycles=%0d, want 12/34", perf_stalls, perf_cycles);
    end
`endif
  endtask

  task automatic test_wrap_zero();
    int want[4] = '{30, 31, 0, 1};
    run_job(30, 30, 4, NEVER, -1, 0, -1, -1, 100);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ((k < rd_addr_q.size() ? rd_addr_q[k] : -1) !== want[k] ||
          (k < wr_addr_q.size() ? wr_addr_q[k] : -1) !== want[k]) begin
        errors++; $display("FAIL wrap_%0d: wrong read or write address, want %0d", k, want[k]);
      end
    end
    run_job(0, 0, 0, NEVER, -1, 0, -1, -1, 20);
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1 || rd_addr_q.size() !== 0 || wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL zero_len: got done at %0d x%0d reads=%0d writes=%0d, want 1 x1 0 0",
                         done_cyc, done_cnt, rd_addr_q.size(), wr_addr_q.size());
    end
`ifdef DOTSEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd2) begin
      errors++; $display("FAIL zero_perf: got cycles=%0d, want 2", perf_cycles);
    end
`endif
  endtask

  task automatic test_idle_ignore();
    res_valid = 1'b1;
    res_data  = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (res_pop !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_ignore: got pop=%b wr=%b busy=%b, want 0/0/0", res_pop, wr_en, busy);
      end
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    run_job(4, 16, 2, NEVER, -1, 6, -1, 6, 100);
    #1;
    checks++;
    if (res_pop !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_pop: got pop=%b busy=%b, want 1/1", res_pop, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, op_push, res_pop, wr_en, busy, done} !== 6'b0 || rd_addr !== '0 ||
        wr_addr !== '0 || wr_data !== '0 || perf_cycles !== '0 || perf_stalls !== '0) begin
      errors++; $display("FAIL reset_async: got pop=%b wr=%b busy=%b done=%b, want all 0", res_pop, wr_en, busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        @(posedge clk); #1 rst_n = 1'b1; res_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || op_push !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_quiet_%0d: got wr=%b done=%b push=%b busy=%b, want 0", k, wr_en, done, op_push, busy);
      end
    end
    @(posedge clk); #1;
    run_job(0, 8, 4, NEVER, -1, 0, -1, -1, 100);
    checks++;
    if (done_cyc !== 10 || wr_addr_q.size() !== 4 || (wr_addr_q.size() > 3 ? wr_addr_q[3] : -1) !== 11) begin
      errors++; $display("FAIL reset_rerun: got done at %0d writes=%0d, want 10 and 4 ending at 11",
                         done_cyc, wr_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_credit();
    test_wrap_zero();
    test_idle_ignore();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
